// File: rtl/delayed_adder.sv
// delayed_adder: registered a+b delivered LATENCY non-held edges after capture.
// Ports: clk, rst (sync, active-high), a, b, in_valid, hold -> sum, out_valid.
module delayed_adder #(
  parameter int WIDTH   = 4,
  parameter int LATENCY = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             in_valid,
  input  logic             hold,
  output logic [WIDTH:0]   sum,
  output logic             out_valid
);

  // The sum is formed at capture, so the line carries WIDTH+1 bits.
  logic [WIDTH:0]     sd [LATENCY];
  logic [LATENCY-1:0] sv;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < LATENCY; i++) begin
        sd[i] <= '0;
      end
      sv        <= '0;
      sum       <= '0;
      out_valid <= 1'b0;
    end else if (!hold) begin
      sd[0] <= {1'b0, a} + {1'b0, b};
      sv[0] <= in_valid;
      for (int i = 1; i < LATENCY; i++) begin
        sd[i] <= sd[i-1];
        sv[i] <= sv[i-1];
      end
      out_valid <= sv[LATENCY-1];
      // A bubble leaves the last valid result on sum.
      if (sv[LATENCY-1]) begin
        sum <= sd[LATENCY-1];
      end
    end
  end

endmodule

// File: tb/tb_delayed_adder.sv
// tb_delayed_adder: directed + random checks of delayed_adder at LATENCY 1/2/5.
// A per-instance queue model tracks results over non-held edges.
module tb_delayed_adder;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] a = '0;
  logic [3:0] b = '0;
  logic       in_valid = 1'b0;
  logic       hold = 1'b0;

  logic [4:0] s [3];
  logic       o [3];

  int tests = 0;
  int fails = 0;

  int         lat [3] = '{1, 2, 5};
  logic [5:0] q [3][$];
  logic [4:0] es [3];
  logic       eo [3];

  always #5 clk = ~clk;

  delayed_adder #(.WIDTH(4), .LATENCY(1)) u1 (
    .clk(clk), .rst(rst), .a(a), .b(b), .in_valid(in_valid),
    .hold(hold), .sum(s[0]), .out_valid(o[0])
  );
  delayed_adder #(.WIDTH(4), .LATENCY(2)) u2 (
    .clk(clk), .rst(rst), .a(a), .b(b), .in_valid(in_valid),
    .hold(hold), .sum(s[1]), .out_valid(o[1])
  );
  delayed_adder #(.WIDTH(4), .LATENCY(5)) u5 (
    .clk(clk), .rst(rst), .a(a), .b(b), .in_valid(in_valid),
    .hold(hold), .sum(s[2]), .out_valid(o[2])
  );

  task automatic chk(input string tag, input logic [4:0] obs,
                     input logic [4:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step(input logic r, input logic h, input logic iv,
                      input logic [3:0] aa, input logic [3:0] bb);
    logic [5:0] e;
    @(negedge clk);
    rst = r; hold = h; in_valid = iv; a = aa; b = bb;
    @(posedge clk);
    for (int k = 0; k < 3; k++) begin
      if (r) begin
        q[k].delete();
        for (int j = 0; j < lat[k]; j++) q[k].push_back(6'd0);
        es[k] = '0;
        eo[k] = 1'b0;
      end else if (!h) begin
        e = q[k].pop_front();
        q[k].push_back({iv, 5'(aa) + 5'(bb)});
        eo[k] = e[5];
        if (e[5]) es[k] = e[4:0];
      end
    end
    #1;
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("model_sum_L%0d", lat[k]), s[k], es[k]);
      chk($sformatf("model_ov_L%0d", lat[k]), {4'd0, o[k]}, {4'd0, eo[k]});
    end
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 1'b0, 4'd0, 4'd0);
  endtask

  initial begin
    // reset
    step(1'b1, 1'b0, 1'b0, 4'd0, 4'd0);
    chk("reset_sum", s[1], 5'd0);
    chk("reset_ov", {4'd0, o[1]}, 5'd0);

    // basic
    step(1'b0, 1'b0, 1'b1, 4'd4, 4'd3);
    idle();
    chk("basic_ov_n1", {4'd0, o[1]}, 5'd0);
    idle();
    chk("basic_sum", s[1], 5'd7);
    chk("basic_ov", {4'd0, o[1]}, 5'd1);
    repeat (4) idle();

    // back-to-back
    step(1'b0, 1'b0, 1'b1, 4'd4, 4'd3);
    step(1'b0, 1'b0, 1'b1, 4'd5, 4'd3);
    idle();
    chk("b2b_sum0", s[1], 5'd7);
    chk("b2b_ov0", {4'd0, o[1]}, 5'd1);
    idle();
    chk("b2b_sum1", s[1], 5'd8);
    chk("b2b_ov1", {4'd0, o[1]}, 5'd1);
    idle();
    chk("b2b_ov_end", {4'd0, o[1]}, 5'd0);
    chk("b2b_sum_kept", s[1], 5'd8);
    repeat (3) idle();

    // carry boundary
    step(1'b0, 1'b0, 1'b1, 4'd15, 4'd15);
    step(1'b0, 1'b0, 1'b1, 4'd15, 4'd1);
    step(1'b0, 1'b0, 1'b1, 4'd0, 4'd0);
    chk("carry_30", s[1], 5'd30);
    idle();
    chk("carry_16", s[1], 5'd16);
    idle();
    chk("carry_0", s[1], 5'd0);
    chk("carry_0_ov", {4'd0, o[1]}, 5'd1);
    repeat (4) idle();

    // hold; operands during hold must be ignored
    step(1'b0, 1'b0, 1'b1, 4'd2, 4'd6);
    step(1'b0, 1'b1, 1'b1, 4'd9, 4'd9);
    step(1'b0, 1'b1, 1'b1, 4'd9, 4'd9);
    step(1'b0, 1'b1, 1'b1, 4'd9, 4'd9);
    chk("hold_ov_held", {4'd0, o[1]}, 5'd0);
    idle();
    chk("hold_ov_n4", {4'd0, o[1]}, 5'd0);
    idle();
    chk("hold_sum", s[1], 5'd8);
    chk("hold_ov", {4'd0, o[1]}, 5'd1);
    // a pending out_valid stays high across hold
    step(1'b0, 1'b1, 1'b0, 4'd0, 4'd0);
    step(1'b0, 1'b1, 1'b0, 4'd0, 4'd0);
    chk("hold_ov_stays", {4'd0, o[1]}, 5'd1);
    idle();
    chk("hold_ov_drop", {4'd0, o[1]}, 5'd0);
    repeat (4) idle();

    // reset mid-flight
    step(1'b0, 1'b0, 1'b1, 4'd9, 4'd4);
    step(1'b1, 1'b1, 1'b1, 4'd1, 4'd1);
    chk("rst_mid_sum", s[1], 5'd0);
    chk("rst_mid_ov", {4'd0, o[1]}, 5'd0);
    for (int i = 0; i < 3; i++) begin
      idle();
      chk("rst_mid_ov_after", {4'd0, o[1]}, 5'd0);
    end

    // capture on first edge after reset
    step(1'b0, 1'b0, 1'b1, 4'd3, 4'd3);
    idle();
    idle();
    chk("post_rst_sum", s[1], 5'd6);
    chk("post_rst_ov", {4'd0, o[1]}, 5'd1);

    // random sweep
    for (int i = 0; i < 100; i++) begin
      step(1'b0, ($urandom_range(0, 3) == 0), $urandom_range(0, 1) == 1,
           4'($urandom), 4'($urandom));
    end
    repeat (6) idle();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
